// File: rtl/fetch_queue.sv
// fetch_queue: consumer end of the fetch-pack interface. Compacts the valid
// slots of 2-wide fetch packs into a circular instruction queue and presents
// up to two in-order instructions per cycle to decode.
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating full/empty cycle
// counters as extra outputs.
//
// Handshakes: a pack is taken on any rising edge where
// fetch_pack_valid & fetch_pack_ready & ~flush. Ready depends on registered
// occupancy only. A dequeue in the same cycle does not free space for that
// cycle's pack. Decode has no per-lane handshake: when decode_ready & ~flush,
// every lane that is presented valid is consumed on that edge.
module fetch_queue #(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_i_flush,
    input  logic        io_i_fetch_pack_valid,
    input  logic        io_i_fetch_pack_bits_valids_0,
    input  logic        io_i_fetch_pack_bits_valids_1,
    input  logic [63:0] io_i_fetch_pack_bits_pc,
    input  logic [31:0] io_i_fetch_pack_bits_insts_0,
    input  logic [31:0] io_i_fetch_pack_bits_insts_1,
    input  logic        io_i_fetch_pack_bits_branch_predict_pack_valid,
    input  logic [63:0] io_i_fetch_pack_bits_branch_predict_pack_target,
    input  logic        io_i_fetch_pack_bits_branch_predict_pack_taken,
    output logic        io_o_fetch_pack_ready,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0] io_o_perf_full_cycles,
    output logic [31:0] io_o_perf_empty_cycles,
`endif
    input  logic        io_i_decode_ready,
    output logic        io_o_valids_0,
    output logic        io_o_valids_1,
    output logic [63:0] io_o_pc_0,
    output logic [63:0] io_o_pc_1,
    output logic [31:0] io_o_insts_0,
    output logic [31:0] io_o_insts_1,
    output logic        io_o_bp_valid_0,
    output logic        io_o_bp_valid_1,
    output logic        io_o_bp_taken_0,
    output logic        io_o_bp_taken_1,
    output logic [63:0] io_o_bp_target_0,
    output logic [63:0] io_o_bp_target_1
);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    // Ready while at least two entries are free, so a full pack always fits.
    localparam cnt_t ROOM_LIMIT = cnt_t'(DEPTH - 2);

    logic [63:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [63:0]      bpt_q  [DEPTH];
    logic [DEPTH-1:0] bpv_q;
    logic [DEPTH-1:0] bptk_q;

    ptr_t head;
    ptr_t tail;
    cnt_t count;

    logic        v0;
    logic        v1;
    logic        both_slots;
    logic        enq_fire;
    logic        deq_fire;
    logic [1:0]  enq_n;
    logic [1:0]  deq_n;
    ptr_t        head_p1;
    ptr_t        tail_p1;
    logic [63:0] pc_plus4;

    // First written entry: slot 0 if valid, else slot 1 (compaction).
    logic        w0_en;
    logic        w1_en;
    logic [63:0] w0_pc;
    logic [31:0] w0_inst;
    logic        w0_bpv;
    logic        w0_bptk;
    logic [63:0] w0_bpt;

    assign v0         = io_i_fetch_pack_bits_valids_0;
    assign v1         = io_i_fetch_pack_bits_valids_1;
    assign both_slots = v0 & v1;
    assign pc_plus4   = io_i_fetch_pack_bits_pc + 64'd4;
    assign head_p1    = head + ptr_t'(1);
    assign tail_p1    = tail + ptr_t'(1);

    assign io_o_fetch_pack_ready = (count <= ROOM_LIMIT);
    assign enq_fire = io_i_fetch_pack_valid & io_o_fetch_pack_ready & ~io_i_flush;
    assign deq_fire = io_i_decode_ready & ~io_i_flush;
    assign enq_n    = enq_fire ? ({1'b0, v0} + {1'b0, v1}) : 2'd0;
    assign deq_n    = !deq_fire ? 2'd0 : (count >= cnt_t'(2)) ? 2'd2 : count[1:0];

    assign w0_en   = enq_fire & (v0 | v1);
    assign w1_en   = enq_fire & both_slots;
    assign w0_pc   = v0 ? io_i_fetch_pack_bits_pc : pc_plus4;
    assign w0_inst = v0 ? io_i_fetch_pack_bits_insts_0 : io_i_fetch_pack_bits_insts_1;
    // The prediction belongs to the highest-addressed valid slot only.
    assign w0_bpv  = both_slots ? 1'b0  : io_i_fetch_pack_bits_branch_predict_pack_valid;
    assign w0_bptk = both_slots ? 1'b0  : io_i_fetch_pack_bits_branch_predict_pack_taken;
    assign w0_bpt  = both_slots ? 64'd0 : io_i_fetch_pack_bits_branch_predict_pack_target;

    // Head/tail/count bookkeeping; flush beats enqueue and dequeue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (io_i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(deq_n);
            tail  <= tail + ptr_t'(enq_n);
            count <= count + cnt_t'(enq_n) - cnt_t'(deq_n);
        end
    end

    // Prediction-valid bits are the only storage cleared by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bpv_q <= '0;
        end else begin
            if (w0_en) bpv_q[tail] <= w0_bpv;
            if (w1_en) bpv_q[tail_p1] <= io_i_fetch_pack_bits_branch_predict_pack_valid;
        end
    end

    // Payload storage; left stale on flush since count gates visibility.
    always_ff @(posedge clock) begin
        if (w0_en) begin
            pc_q[tail]   <= w0_pc;
            inst_q[tail] <= w0_inst;
            bptk_q[tail] <= w0_bptk;
            bpt_q[tail]  <= w0_bpt;
        end
        if (w1_en) begin
            pc_q[tail_p1]   <= pc_plus4;
            inst_q[tail_p1] <= io_i_fetch_pack_bits_insts_1;
            bptk_q[tail_p1] <= io_i_fetch_pack_bits_branch_predict_pack_taken;
            bpt_q[tail_p1]  <= io_i_fetch_pack_bits_branch_predict_pack_target;
        end
    end

    // Lane outputs straight from registers; invalid lanes read as zero.
    always_comb begin
        io_o_valids_0    = 1'b0;
        io_o_pc_0        = 64'd0;
        io_o_insts_0     = 32'd0;
        io_o_bp_valid_0  = 1'b0;
        io_o_bp_taken_0  = 1'b0;
        io_o_bp_target_0 = 64'd0;
        io_o_valids_1    = 1'b0;
        io_o_pc_1        = 64'd0;
        io_o_insts_1     = 32'd0;
        io_o_bp_valid_1  = 1'b0;
        io_o_bp_taken_1  = 1'b0;
        io_o_bp_target_1 = 64'd0;
        if (count != '0) begin
            io_o_valids_0    = 1'b1;
            io_o_pc_0        = pc_q[head];
            io_o_insts_0     = inst_q[head];
            io_o_bp_valid_0  = bpv_q[head];
            io_o_bp_taken_0  = bptk_q[head];
            io_o_bp_target_0 = bpt_q[head];
        end
        if (count >= cnt_t'(2)) begin
            io_o_valids_1    = 1'b1;
            io_o_pc_1        = pc_q[head_p1];
            io_o_insts_1     = inst_q[head_p1];
            io_o_bp_valid_1  = bpv_q[head_p1];
            io_o_bp_taken_1  = bptk_q[head_p1];
            io_o_bp_target_1 = bpt_q[head_p1];
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;

    // Saturating stall/starvation counters; only reset clears them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if (io_i_fetch_pack_valid && !io_o_fetch_pack_ready && perf_full_q != '1)
                perf_full_q <= perf_full_q + 32'd1;
            if (count == '0 && io_i_decode_ready && perf_empty_q != '1)
                perf_empty_q <= perf_empty_q + 32'd1;
        end
    end

    assign io_o_perf_full_cycles  = perf_full_q;
    assign io_o_perf_empty_cycles = perf_empty_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. The model queue exp_q
// holds the expected entries in order; its size is the expected occupancy.
module tb_fetch_queue;

    localparam int DEPTH = 16;
    localparam int EW    = 162;  // {pc, inst, bp_valid, bp_taken, bp_target}

    logic        clock;
    logic        reset;
    logic        flush;
    logic        pv;
    logic        v0;
    logic        v1;
    logic [63:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        bpv;
    logic [63:0] bpt;
    logic        bptk;
    logic        dr;

    logic        ready;
    logic        o_v0, o_v1;
    logic [63:0] o_pc0, o_pc1;
    logic [31:0] o_i0, o_i1;
    logic        o_bpv0, o_bpv1, o_bptk0, o_bptk1;
    logic [63:0] o_bpt0, o_bpt1;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_full;
    logic [31:0] perf_empty;
`endif

    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int m_full = 0;
    int m_empty = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .io_i_flush(flush),
        .io_i_fetch_pack_valid(pv),
        .io_i_fetch_pack_bits_valids_0(v0),
        .io_i_fetch_pack_bits_valids_1(v1),
        .io_i_fetch_pack_bits_pc(pc),
        .io_i_fetch_pack_bits_insts_0(i0),
        .io_i_fetch_pack_bits_insts_1(i1),
        .io_i_fetch_pack_bits_branch_predict_pack_valid(bpv),
        .io_i_fetch_pack_bits_branch_predict_pack_target(bpt),
        .io_i_fetch_pack_bits_branch_predict_pack_taken(bptk),
        .io_o_fetch_pack_ready(ready),
`ifdef FETCH_QUEUE_PERF_EN
        .io_o_perf_full_cycles(perf_full),
        .io_o_perf_empty_cycles(perf_empty),
`endif
        .io_i_decode_ready(dr),
        .io_o_valids_0(o_v0),
        .io_o_valids_1(o_v1),
        .io_o_pc_0(o_pc0),
        .io_o_pc_1(o_pc1),
        .io_o_insts_0(o_i0),
        .io_o_insts_1(o_i1),
        .io_o_bp_valid_0(o_bpv0),
        .io_o_bp_valid_1(o_bpv1),
        .io_o_bp_taken_0(o_bptk0),
        .io_o_bp_taken_1(o_bptk1),
        .io_o_bp_target_0(o_bpt0),
        .io_o_bp_target_1(o_bpt1)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] mk(input logic [63:0] p, input logic [31:0] i,
                                         input logic bv, input logic bk, input logic [63:0] bt);
        return {p, i, bv, bk, bt};
    endfunction

    function automatic logic [EW-1:0] lane0();
        return {o_pc0, o_i0, o_bpv0, o_bptk0, o_bpt0};
    endfunction

    function automatic logic [EW-1:0] lane1();
        return {o_pc1, o_i1, o_bpv1, o_bptk1, o_bpt1};
    endfunction

    function automatic logic [EW-1:0] exp_lane(input int k);
        if (exp_q.size() > k) return exp_q[k];
        return '0;
    endfunction

    function automatic logic exp_ready();
        return (DEPTH - exp_q.size()) >= 2;
    endfunction

    // Driver: place a pack on the inputs for the coming edge.
    task automatic set_pack(input logic valid, input logic s0, input logic s1,
                            input logic [63:0] p, input logic [31:0] a, input logic [31:0] b,
                            input logic bv, input logic bk, input logic [63:0] bt);
        pv = valid; v0 = s0; v1 = s1; pc = p; i0 = a; i1 = b;
        bpv = bv; bptk = bk; bpt = bt;
    endtask

    // Driver: advance one edge and apply the same edge to the model.
    task automatic tick();
        bit rdy;
        int n;
        rdy = exp_ready();
        if (pv && !rdy) m_full++;
        if (exp_q.size() == 0 && dr) m_empty++;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (dr) begin
                n = (exp_q.size() > 2) ? 2 : exp_q.size();
                repeat (n) void'(exp_q.pop_front());
            end
            if (pv && rdy) begin
                if (v0) exp_q.push_back(mk(pc, i0, v1 ? 1'b0 : bpv, v1 ? 1'b0 : bptk, v1 ? 64'd0 : bpt));
                if (v1) exp_q.push_back(mk(pc + 64'd4, i1, bpv, bptk, bpt));
            end
        end
        @(negedge clock);
    endtask

    task automatic clear_queue();
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        dr = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0; dr = 1'b0;
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        repeat (3) @(negedge clock);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if ({o_v0, o_v1} !== 2'b00) begin errors++; $display("FAIL reset_valids got=%b exp=00", {o_v0, o_v1}); end
        reset = 1'b1;
        checks++; if (lane0() !== '0) begin errors++; $display("FAIL reset_lane0 got=%h exp=0", lane0()); end
        checks++; if (lane1() !== '0) begin errors++; $display("FAIL reset_lane1 got=%h exp=0", lane1()); end
    endtask

    task automatic test_basic();
        dr = 1'b0;
        set_pack(1, 1, 1, 64'h8000_0000, 32'h11, 32'h22, 0, 0, 64'd0);
        tick();
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        checks++; if ({o_v0, o_v1} !== 2'b11) begin errors++; $display("FAIL basic_valids got=%b exp=11", {o_v0, o_v1}); end
        checks++; if (o_pc0 !== 64'h8000_0000) begin errors++; $display("FAIL basic_pc0 got=%h exp=80000000", o_pc0); end
        checks++; if (o_pc1 !== 64'h8000_0004) begin errors++; $display("FAIL basic_pc1 got=%h exp=80000004", o_pc1); end
        checks++; if ({o_i0, o_i1} !== {32'h11, 32'h22}) begin errors++; $display("FAIL basic_insts got=%h/%h exp=11/22", o_i0, o_i1); end
        checks++; if (lane1() !== exp_lane(1)) begin errors++; $display("FAIL basic_lane1 got=%h exp=%h", lane1(), exp_lane(1)); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", ready); end
        clear_queue();
    endtask

    task automatic test_bp_placement();
        dr = 1'b0;
        set_pack(1, 0, 1, 64'h8000_0008, 32'h0, 32'h99, 1, 1, 64'h8000_0100);
        tick();
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        checks++; if ({o_v0, o_v1} !== 2'b10) begin errors++; $display("FAIL bp1_valids got=%b exp=10", {o_v0, o_v1}); end
        checks++; if ({o_pc0, o_bpv0, o_bptk0, o_bpt0} !== {64'h8000_000C, 1'b1, 1'b1, 64'h8000_0100})
            begin errors++; $display("FAIL bp1_entry got=%h/%b/%b/%h exp=8000000c/1/1/80000100", o_pc0, o_bpv0, o_bptk0, o_bpt0); end
        // Consume that entry while a both-valid pack with a prediction arrives.
        dr = 1'b1;
        set_pack(1, 1, 1, 64'h8000_0010, 32'h33, 32'h44, 1, 0, 64'h8000_0200);
        checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL bp1_consume got=%h exp=%h", lane0(), exp_lane(0)); end
        tick();
        dr = 1'b0;
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        checks++; if ({o_bpv0, o_bpv1} !== 2'b01) begin errors++; $display("FAIL bp2_lanes got=%b exp=01", {o_bpv0, o_bpv1}); end
        checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL bp2_lane0 got=%h exp=%h", lane0(), exp_lane(0)); end
        checks++; if (lane1() !== exp_lane(1)) begin errors++; $display("FAIL bp2_lane1 got=%h exp=%h", lane1(), exp_lane(1)); end
        // Slot-0-only pack keeps its prediction.
        dr = 1'b1;
        set_pack(1, 1, 0, 64'h8000_0020, 32'h55, 32'h66, 1, 1, 64'h8000_0300);
        tick();
        dr = 1'b0;
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        checks++; if ({o_v0, o_v1} !== 2'b10) begin errors++; $display("FAIL bp3_valids got=%b exp=10", {o_v0, o_v1}); end
        checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL bp3_lane0 got=%h exp=%h", lane0(), exp_lane(0)); end
        clear_queue();
    endtask

    task automatic test_full();
        dr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_pack(1, 1, 1, 64'h2000 + 64'(8 * k), 32'(2 * k), 32'(2 * k + 1), 0, 0, 64'd0);
            tick();
        end
        checks++; if (ready !== 1'b1 || exp_q.size() != 14) begin errors++; $display("FAIL full14_ready got=%b exp=1", ready); end
        set_pack(1, 1, 1, 64'h2038, 32'hE, 32'hF, 0, 0, 64'd0);
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full16_ready got=%b exp=0", ready); end
        // Ninth pack held for ten cycles must not enter.
        set_pack(1, 1, 1, 64'h2040, 32'hAA, 32'hBB, 1, 1, 64'h5);
        repeat (10) tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got=%b exp=0", ready); end
        checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL full_hold_lane0 got=%h exp=%h", lane0(), exp_lane(0)); end
        checks++; if (lane1() !== exp_lane(1)) begin errors++; $display("FAIL full_hold_lane1 got=%h exp=%h", lane1(), exp_lane(1)); end
`ifdef FETCH_QUEUE_PERF_EN
        checks++; if (perf_full !== 32'(m_full)) begin errors++; $display("FAIL perf_full got=%0d exp=%0d", perf_full, m_full); end
`endif
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        dr = 1'b1;
        tick();
        dr = 1'b0;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_drain_ready got=%b exp=1", ready); end
        checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL full_drain_lane0 got=%h exp=%h", lane0(), exp_lane(0)); end
        clear_queue();
    endtask

    task automatic test_flush();
        dr = 1'b0;
        set_pack(1, 1, 1, 64'h3000, 32'h1, 32'h2, 0, 0, 64'd0); tick();
        set_pack(1, 1, 1, 64'h3008, 32'h3, 32'h4, 0, 0, 64'd0); tick();
        set_pack(1, 1, 0, 64'h3010, 32'h5, 32'h6, 0, 0, 64'd0); tick();
        checks++; if (lane0() !== exp_lane(0) || exp_q.size() != 5) begin errors++; $display("FAIL flush_pre_lane0 got=%h exp=%h", lane0(), exp_lane(0)); end
        flush = 1'b1; dr = 1'b1;
        set_pack(1, 1, 1, 64'h3018, 32'h7, 32'h8, 1, 1, 64'h9);
        tick();
        flush = 1'b0; dr = 1'b0;
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        checks++; if ({o_v0, o_v1} !== 2'b00) begin errors++; $display("FAIL flush_valids got=%b exp=00", {o_v0, o_v1}); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready); end
        checks++; if (lane0() !== '0) begin errors++; $display("FAIL flush_lane0 got=%h exp=0", lane0()); end
        set_pack(1, 1, 1, 64'h3100, 32'hC1, 32'hC2, 0, 0, 64'd0);
        tick();
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL flush_post_lane0 got=%h exp=%h", lane0(), exp_lane(0)); end
        checks++; if (lane1() !== exp_lane(1)) begin errors++; $display("FAIL flush_post_lane1 got=%h exp=%h", lane1(), exp_lane(1)); end
        clear_queue();
    endtask

    task automatic test_wraparound();
        logic [63:0] next_pc;
        int cycles;
        next_pc = 64'h4000;
        dr = 1'b1;
        // Phase 0 streams 40 packs, phase 1 drains.
        cycles = 0;
        for (int k = 0; k < 44; k++) begin
            if (k < 40) set_pack(1, 1, 1, 64'h4000 + 64'(8 * k), $urandom, $urandom, 0, 0, 64'd0);
            else        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
            checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL wrap_lane0 k=%0d got=%h exp=%h", k, lane0(), exp_lane(0)); end
            checks++; if (lane1() !== exp_lane(1)) begin errors++; $display("FAIL wrap_lane1 k=%0d got=%h exp=%h", k, lane1(), exp_lane(1)); end
            if (o_v0 === 1'b1) begin
                checks++; if (o_pc0 !== next_pc) begin errors++; $display("FAIL wrap_seq0 got=%h exp=%h", o_pc0, next_pc); end
                next_pc = next_pc + 64'd4;
            end
            if (o_v1 === 1'b1) begin
                checks++; if (o_pc1 !== next_pc) begin errors++; $display("FAIL wrap_seq1 got=%h exp=%h", o_pc1, next_pc); end
                next_pc = next_pc + 64'd4;
            end
            tick();
            cycles++;
        end
        checks++; if (next_pc !== 64'h4000 + 64'(80 * 4)) begin errors++; $display("FAIL wrap_total got=%h exp=%h", next_pc, 64'h4000 + 64'(320)); end
        // Random slot patterns and decode stalls.
        for (int k = 0; k < 120; k++) begin
            set_pack(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     64'h9000 + 64'(8 * k), $urandom, $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), {32'd0, $urandom});
            dr = 1'($urandom_range(0, 2) != 0);
            checks++; if (ready !== exp_ready()) begin errors++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, ready, exp_ready()); end
            checks++; if (lane0() !== exp_lane(0)) begin errors++; $display("FAIL rand_lane0 k=%0d got=%h exp=%h", k, lane0(), exp_lane(0)); end
            checks++; if (lane1() !== exp_lane(1)) begin errors++; $display("FAIL rand_lane1 k=%0d got=%h exp=%h", k, lane1(), exp_lane(1)); end
            tick();
        end
        clear_queue();
    endtask

`ifdef FETCH_QUEUE_PERF_EN
    task automatic test_perf();
        set_pack(0, 0, 0, 64'd0, 32'd0, 32'd0, 0, 0, 64'd0);
        dr = 1'b1;
        repeat (3) tick();
        dr = 1'b0;
        checks++; if (perf_empty !== 32'(m_empty)) begin errors++; $display("FAIL perf_empty got=%0d exp=%0d", perf_empty, m_empty); end
        checks++; if (perf_full !== 32'(m_full)) begin errors++; $display("FAIL perf_full_end got=%0d exp=%0d", perf_full, m_full); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bp_placement();
        test_full();
        test_flush();
        test_wraparound();
`ifdef FETCH_QUEUE_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
